// File: rtl/datapath_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_seq_pkg
// Description : Shared types and constants for the datapath sequencing
//               controller: FSM state encoding, default nibble count and the
//               ALU mode type driven onto the datapath MS pins.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_seq_pkg;

    // Number of 4-bit nibbles that make up one 16-bit operand.
    localparam int NIBBLES_DEF = 4;

    // 3-bit ALU mode as presented to the datapath MS input.
    typedef logic [2:0] alu_mode_t;

    // Controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage : datapath_seq_pkg
`default_nettype wire

// File: rtl/datapath_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : datapath_seq_ctrl
// Description : Sequencing controller for the 16-bit register/ALU datapath.
//               Accepts a start command with an ALU mode, shifts two operands
//               into the datapath one nibble at a time (MS nibble first),
//               waits for the ALU to settle, captures the result and pulses
//               result_valid for one cycle.
// Ports       : CLK, RST          - clock (rising edge), async active-high reset
//               start, op, abort  - command strobe, ALU mode, synchronous abort
//               key_valid/key_data/key_ready - nibble source handshake
//               dp_din, dp_we, dp_w1, dp_level, dp_ms - registered datapath
//                                   control (Din, WE, W1, level, MS)
//               alu_out           - combinational ALU result from datapath
//               result, result_valid - captured result and completion pulse
//               busy              - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_seq_ctrl
    import datapath_seq_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF,
    parameter int W       = 4 * NIBBLES   // must equal 4*NIBBLES
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         abort,
    input  logic         key_valid,
    input  logic [3:0]   key_data,
    output logic         key_ready,
    output logic [3:0]   dp_din,
    output logic         dp_we,
    output logic         dp_w1,
    output logic         dp_level,
    output logic [2:0]   dp_ms,
    input  logic [W-1:0] alu_out,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         busy
);

    localparam int                 c_CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NIBBLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_last;
    logic               w_start_ok;

    assign key_ready    = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign w_accept     = key_valid && key_ready;
    assign w_last       = (r_cnt == c_LAST);
    // abort beats start even in IDLE, so a simultaneous start is dropped.
    assign w_start_ok   = (r_state == ST_IDLE) && start && !abort;
    assign busy         = (r_state != ST_IDLE);
    assign result_valid = (r_state == ST_DONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (start)              w_state_nxt = ST_LOAD_A;
                ST_LOAD_A:  if (w_accept && w_last) w_state_nxt = ST_LOAD_B;
                ST_LOAD_B:  if (w_accept && w_last) w_state_nxt = ST_SETTLE;
                // SETTLE lets the last B write land; CAPTURE then sees a
                // full cycle of settled alu_out before sampling it.
                ST_SETTLE:  w_state_nxt = ST_CAPTURE;
                ST_CAPTURE: w_state_nxt = ST_DONE;
                ST_DONE:    w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Nibble counter, registered datapath controls and result holding
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            dp_din   <= 4'd0;
            dp_we    <= 1'b0;
            dp_w1    <= 1'b0;
            dp_level <= 1'b0;
            dp_ms    <= 3'd0;
            result   <= '0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted nibble.
            dp_we    <= 1'b0;
            dp_level <= 1'b0;

            if (abort || w_start_ok) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= w_last ? '0 : (r_cnt + c_ONE);
            end

            if (!abort && w_accept) begin
                dp_din   <= key_data;
                dp_we    <= 1'b1;
                dp_level <= 1'b1;
                dp_w1    <= (r_state == ST_LOAD_B);
            end

            // op is latched only on an accepted start so MS is stable for
            // the whole run.
            if (w_start_ok) begin
                dp_ms <= op;
            end

            if (!abort && (r_state == ST_CAPTURE)) begin
                result <= alu_out;
            end
        end
    end

endmodule : datapath_seq_ctrl
`default_nettype wire
